// File: rtl/yval_pkg.sv
// Shared constants, state encoding and element type for the Y-value fetch sequencer.
package yval_pkg;

  localparam int HW_DEF = 24;

  function automatic int calc_epw(input int mem_w, input int yw);
    return mem_w / yw;
  endfunction

  function automatic int calc_wpr(input int n, input int epw);
    return (n + epw - 1) / epw;
  endfunction

  // Word address of Y[i][j]: full rows first, then the word holding column j.
  function automatic int elem_addr(input int i, input int j, input int wpr, input int epw);
    return i * wpr + j / epw;
  endfunction

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_RD_RR = 3'd1;
  localparam logic [2:0] ST_RD_RC = 3'd2;
  localparam logic [2:0] ST_RD_CC = 3'd3;
  localparam logic [2:0] ST_EMIT  = 3'd4;
  localparam logic [2:0] ST_BUSY  = 3'd5;

  typedef struct packed {
    logic [HW_DEF-1:0] re;
    logic [HW_DEF-1:0] im;
  } elem_t;

endpackage

// File: rtl/yval_lane_sel.sv
// Extracts the {real,imag} element of column col from one yMem word.
module yval_lane_sel
  import yval_pkg::*;
#(
  parameter int MEM_W = 256,
  parameter int YW    = 48,
  parameter int IDX_W = 16
) (
  input  logic [MEM_W-1:0] word,
  input  logic [IDX_W-1:0] col,
  output logic [YW-1:0]    elem
);

  localparam int EPW = calc_epw(MEM_W, YW);

  logic [IDX_W-1:0] lane;

  assign lane = IDX_W'(int'(col) % EPW);

  // one-hot OR mux over the populated lanes
  always_comb begin
    elem = '0;
    for (int i = 0; i < EPW; i++) begin
      elem = elem | (word[i*YW +: YW] & {YW{lane == IDX_W'(i)}});
    end
  end

  generate
    if (EPW * YW < MEM_W) begin : g_pad
      logic unused_pad;
      assign unused_pad = ^word[MEM_W-1:EPW*YW];
    end
  endgenerate

endmodule

// File: rtl/yval_fetch_seq.sv
// Fetches Y_rr, Y_rc, Y_cc for one admittance change and hands them to calc_y as a single beat.
module yval_fetch_seq
  import yval_pkg::*;
#(
  parameter int IDX_W  = 16,
  parameter int HW     = 24,
  parameter int MEM_W  = 256,
  parameter int N      = 8,
  parameter int AW     = 16,
  parameter int RD_LAT = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             chng_valid,
  output logic             chng_ready,
  input  logic [IDX_W-1:0] chng_row,
  input  logic [IDX_W-1:0] chng_col,
  input  logic [HW-1:0]    chng_real,
  input  logic [HW-1:0]    chng_img,
  output logic             ymem_rd_en,
  output logic [AW-1:0]    ymem_addr,
  input  logic [MEM_W-1:0] ymem_data,
  output logic             op_valid,
  input  logic             op_ready,
  output logic [2*HW-1:0]  op_yVal_rr,
  output logic [2*HW-1:0]  op_yVal_rc,
  output logic [2*HW-1:0]  op_yVal_cc,
  output logic [2*HW-1:0]  op_delta,
  output logic [IDX_W-1:0] op_row,
  output logic [IDX_W-1:0] op_col,
  output logic             op_EX_EN,
  input  logic             calc_done,
  output logic             err_range
);

  localparam int YW    = 2 * HW;
  localparam int EPW   = calc_epw(MEM_W, YW);
  localparam int WPR   = calc_wpr(N, EPW);
  localparam int CNT_W = $clog2(RD_LAT + 1);

  logic [2:0]       state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [IDX_W-1:0] row_r, col_r;
  logic [YW-1:0]    delta_r, y_rr_r, y_rc_r, y_cc_r;
  logic [MEM_W-1:0] word_r;
  logic             op_valid_r, chng_ready_r, rd_en_r, err_r;
  logic [AW-1:0]    addr_r;

  logic [AW-1:0]    addr_in_s, addr_rr_s, addr_rc_s, addr_cc_s;
  logic             in_range_s, diag_s, same_rc_s, reuse_s, data_ready_s;
  logic [MEM_W-1:0] sel_word_s;
  logic [IDX_W-1:0] sel_col_s;
  logic [YW-1:0]    lane_elem_s;

  assign addr_in_s  = AW'(elem_addr(int'(chng_row), int'(chng_row), WPR, EPW));
  assign addr_rr_s  = AW'(elem_addr(int'(row_r), int'(row_r), WPR, EPW));
  assign addr_rc_s  = AW'(elem_addr(int'(row_r), int'(col_r), WPR, EPW));
  assign addr_cc_s  = AW'(elem_addr(int'(col_r), int'(col_r), WPR, EPW));
  assign in_range_s = (int'(chng_row) < N) && (int'(chng_col) < N);
  assign diag_s     = (row_r == col_r);
  assign same_rc_s  = (addr_rc_s == addr_rr_s);
  assign data_ready_s = (cnt_r == CNT_W'(RD_LAT));

  // Y_rc sharing the Y_rr word is pulled from the saved word while the Y_cc read is in flight.
  assign reuse_s    = (state_r == ST_RD_CC) && same_rc_s && (cnt_r == CNT_W'(0));
  assign sel_word_s = reuse_s ? word_r : ymem_data;
  assign sel_col_s  = (state_r == ST_RD_RR) ? row_r : col_r;

  yval_lane_sel #(
    .MEM_W (MEM_W),
    .YW    (YW),
    .IDX_W (IDX_W)
  ) u_lane_sel (
    .word (sel_word_s),
    .col  (sel_col_s),
    .elem (lane_elem_s)
  );

  // fetch sequencer state, read strobes and captured beat fields
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r      <= ST_IDLE;
      cnt_r        <= '0;
      row_r        <= '0;
      col_r        <= '0;
      delta_r      <= '0;
      word_r       <= '0;
      y_rr_r       <= '0;
      y_rc_r       <= '0;
      y_cc_r       <= '0;
      op_valid_r   <= 1'b0;
      chng_ready_r <= 1'b1;
      rd_en_r      <= 1'b0;
      addr_r       <= '0;
      err_r        <= 1'b0;
    end else begin
      rd_en_r <= 1'b0;
      err_r   <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (chng_valid) begin
            row_r   <= chng_row;
            col_r   <= chng_col;
            delta_r <= {chng_real, chng_img};
            if (in_range_s) begin
              state_r      <= ST_RD_RR;
              chng_ready_r <= 1'b0;
              rd_en_r      <= 1'b1;
              addr_r       <= addr_in_s;
              cnt_r        <= '0;
            end else begin
              err_r <= 1'b1;
            end
          end
        end
        ST_RD_RR: begin
          if (data_ready_s) begin
            y_rr_r <= lane_elem_s;
            word_r <= ymem_data;
            cnt_r  <= '0;
            if (diag_s) begin
              y_rc_r     <= lane_elem_s;
              y_cc_r     <= lane_elem_s;
              op_valid_r <= 1'b1;
              state_r    <= ST_EMIT;
            end else if (same_rc_s) begin
              rd_en_r <= 1'b1;
              addr_r  <= addr_cc_s;
              state_r <= ST_RD_CC;
            end else begin
              rd_en_r <= 1'b1;
              addr_r  <= addr_rc_s;
              state_r <= ST_RD_RC;
            end
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        ST_RD_RC: begin
          if (data_ready_s) begin
            y_rc_r  <= lane_elem_s;
            rd_en_r <= 1'b1;
            addr_r  <= addr_cc_s;
            cnt_r   <= '0;
            state_r <= ST_RD_CC;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        ST_RD_CC: begin
          if (data_ready_s) begin
            y_cc_r     <= lane_elem_s;
            op_valid_r <= 1'b1;
            state_r    <= ST_EMIT;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
            if (reuse_s) begin
              y_rc_r <= lane_elem_s;
            end
          end
        end
        ST_EMIT: begin
          if (op_ready) begin
            op_valid_r <= 1'b0;
            state_r    <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (calc_done) begin
            chng_ready_r <= 1'b1;
            state_r      <= ST_IDLE;
          end
        end
        default: begin
          state_r      <= ST_IDLE;
          op_valid_r   <= 1'b0;
          chng_ready_r <= 1'b1;
        end
      endcase
    end
  end

  assign chng_ready = chng_ready_r;
  assign ymem_rd_en = rd_en_r;
  assign ymem_addr  = addr_r;
  assign op_valid   = op_valid_r;
  assign op_yVal_rr = y_rr_r;
  assign op_yVal_rc = y_rc_r;
  assign op_yVal_cc = y_cc_r;
  assign op_delta   = delta_r;
  assign op_row     = row_r;
  assign op_col     = col_r;
  assign op_EX_EN   = op_valid_r & op_ready;
  assign err_range  = err_r;

endmodule

// File: tb/tb_yval_fetch_seq.sv
// Directed bench for yval_fetch_seq with default parameters and a one-cycle-latency yMem model.
module tb_yval_fetch_seq;
  import yval_pkg::*;

  logic         clock = 1'b0;
  logic         reset;
  logic         chng_valid, chng_ready;
  logic [15:0]  chng_row, chng_col;
  logic [23:0]  chng_real, chng_img;
  logic         ymem_rd_en;
  logic [15:0]  ymem_addr;
  logic [255:0] ymem_data;
  logic         op_valid, op_ready, op_EX_EN, calc_done, err_range;
  logic [47:0]  op_yVal_rr, op_yVal_rc, op_yVal_cc, op_delta;
  logic [15:0]  op_row, op_col;

  int total = 0;
  int bad = 0;
  int ex_cnt = 0;
  int err_cnt = 0;
  int overlap = 0;
  logic prev_rd = 1'b0;
  logic [15:0] rd_q[$];
  int lat;
  int ex_before;

  yval_fetch_seq dut (
    .clock(clock), .reset(reset),
    .chng_valid(chng_valid), .chng_ready(chng_ready),
    .chng_row(chng_row), .chng_col(chng_col),
    .chng_real(chng_real), .chng_img(chng_img),
    .ymem_rd_en(ymem_rd_en), .ymem_addr(ymem_addr), .ymem_data(ymem_data),
    .op_valid(op_valid), .op_ready(op_ready),
    .op_yVal_rr(op_yVal_rr), .op_yVal_rc(op_yVal_rc), .op_yVal_cc(op_yVal_cc),
    .op_delta(op_delta), .op_row(op_row), .op_col(op_col),
    .op_EX_EN(op_EX_EN), .calc_done(calc_done), .err_range(err_range)
  );

  always #5 clock = ~clock;

  // Element at word a, lane l: distinct real/imag tags per address and lane.
  function automatic logic [47:0] elem(input int a, input int l);
    elem_t e;
    e.re = 24'(32'h100000 + a * 16 + l);
    e.im = 24'(32'h200000 + a * 16 + l);
    return e;
  endfunction

  function automatic logic [255:0] mem_word(input int a);
    logic [255:0] w;
    w = '0;
    for (int l = 0; l < 5; l++) w[l*48 +: 48] = elem(a, l);
    w[255:240] = 16'hDEAD;
    return w;
  endfunction

  // yMem model plus read/handshake monitors
  always @(posedge clock) begin
    if (ymem_rd_en) begin
      ymem_data <= mem_word(int'(ymem_addr));
      rd_q.push_back(ymem_addr);
    end
    if (ymem_rd_en && prev_rd) overlap++;
    prev_rd <= ymem_rd_en;
    if (op_EX_EN) ex_cnt++;
    if (err_range) err_cnt++;
  end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input int r, input int c, input logic [23:0] re, input logic [23:0] im);
    chng_valid = 1'b1;
    chng_row   = 16'(r);
    chng_col   = 16'(c);
    chng_real  = re;
    chng_img   = im;
    tick();
    chng_valid = 1'b0;
  endtask

  // latency counted from the acceptance cycle; bounded wait
  task automatic wait_op(output int l);
    l = 1;
    while (!op_valid && l < 40) begin
      tick();
      l++;
    end
  endtask

  task automatic chk_reads(input int n, input int a0, input int a1, input int a2);
    int exp_a[3];
    exp_a = '{a0, a1, a2};
    chk("read_count", 64'(rd_q.size()), 64'(n));
    for (int i = 0; i < n; i++) begin
      if (i < rd_q.size()) chk("read_addr", 64'(rd_q[i]), 64'(exp_a[i]));
    end
  endtask

  task automatic finish_beat;
    ex_before = ex_cnt;
    op_ready = 1'b1;
    #1;
    chk("ex_en_on_handshake", 64'(op_EX_EN), 64'd1);
    tick();
    op_ready = 1'b0;
    chk("valid_drops", 64'(op_valid), 64'd0);
    chk("ex_en_once", 64'(ex_cnt - ex_before), 64'd1);
    chk("ready_low_busy", 64'(chng_ready), 64'd0);
    calc_done = 1'b1;
    tick();
    calc_done = 1'b0;
    chk("ready_after_done", 64'(chng_ready), 64'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0; chng_valid = 1'b0; chng_row = '0; chng_col = '0;
    chng_real = '0; chng_img = '0; op_ready = 1'b0; calc_done = 1'b0;
    tick(); tick();
    chk("rst_ready", 64'(chng_ready), 64'd1);
    chk("rst_op_valid", 64'(op_valid), 64'd0);
    chk("rst_rd_en", 64'(ymem_rd_en), 64'd0);
    chk("rst_addr", 64'(ymem_addr), 64'd0);
    chk("rst_yrr", 64'(op_yVal_rr), 64'd0);
    chk("rst_err", 64'(err_range), 64'd0);
    reset = 1'b1;
    tick();

    // r=1, c=6: three reads 2,3,13 all lane 1
    rd_q.delete();
    send(1, 6, 24'h0ABCDE, 24'h123456);
    chk("t1_rd_en", 64'(ymem_rd_en), 64'd1);
    chk("t1_first_addr", 64'(ymem_addr), 64'd2);
    chk("t1_ready_drop", 64'(chng_ready), 64'd0);
    wait_op(lat);
    chk("t1_latency", 64'(lat), 64'd7);
    chk_reads(3, 2, 3, 13);
    chk("t1_rr", 64'(op_yVal_rr), 64'(elem(2, 1)));
    chk("t1_rc", 64'(op_yVal_rc), 64'(elem(3, 1)));
    chk("t1_cc", 64'(op_yVal_cc), 64'(elem(13, 1)));
    chk("t1_delta", 64'(op_delta), 64'h0ABCDE123456);
    chk("t1_row", 64'(op_row), 64'd1);
    chk("t1_col", 64'(op_col), 64'd6);
    finish_beat();

    // r=0, c=2: Y_rc shares word 0
    rd_q.delete();
    send(0, 2, 24'h000011, 24'hFFFFEE);
    wait_op(lat);
    chk("t2_latency", 64'(lat), 64'd5);
    chk_reads(2, 0, 4, 0);
    chk("t2_rr", 64'(op_yVal_rr), 64'(elem(0, 0)));
    chk("t2_rc", 64'(op_yVal_rc), 64'(elem(0, 2)));
    chk("t2_cc", 64'(op_yVal_cc), 64'(elem(4, 2)));
    finish_beat();

    // r=c=3: single read
    rd_q.delete();
    send(3, 3, 24'h333333, 24'h444444);
    wait_op(lat);
    chk("t3_latency", 64'(lat), 64'd3);
    chk_reads(1, 6, 0, 0);
    chk("t3_rr", 64'(op_yVal_rr), 64'(elem(6, 3)));
    chk("t3_rc", 64'(op_yVal_rc), 64'(elem(6, 3)));
    chk("t3_cc", 64'(op_yVal_cc), 64'(elem(6, 3)));
    finish_beat();

    // r=8 out of range
    rd_q.delete();
    send(8, 1, 24'h1, 24'h2);
    chk("t4_err_pulse", 64'(err_range), 64'd1);
    chk("t4_ready_kept", 64'(chng_ready), 64'd1);
    chk("t4_no_rd", 64'(ymem_rd_en), 64'd0);
    tick();
    chk("t4_err_single", 64'(err_range), 64'd0);
    tick(); tick();
    chk("t4_no_reads", 64'(rd_q.size()), 64'd0);
    chk("t4_err_count", 64'(err_cnt), 64'd1);

    // r=2, c=7 with op_ready held low, early calc_done and a competing record
    rd_q.delete();
    send(2, 7, 24'hABCDEF, 24'h654321);
    wait_op(lat);
    chk("t5_latency", 64'(lat), 64'd7);
    ex_before = ex_cnt;
    chng_valid = 1'b1; chng_row = 16'd4; chng_col = 16'd5;
    for (int i = 0; i < 10; i++) begin
      calc_done = (i == 3);
      chk("t5_hold_valid", 64'(op_valid), 64'd1);
      chk("t5_hold_no_ex", 64'(op_EX_EN), 64'd0);
      chk("t5_hold_rc", 64'(op_yVal_rc), 64'(elem(5, 2)));
      chk("t5_hold_ready", 64'(chng_ready), 64'd0);
      tick();
    end
    calc_done = 1'b0;
    chk("t5_rr", 64'(op_yVal_rr), 64'(elem(4, 2)));
    chk("t5_cc", 64'(op_yVal_cc), 64'(elem(15, 2)));
    chk("t5_ex_hold_count", 64'(ex_cnt - ex_before), 64'd0);
    op_ready = 1'b1;
    #1;
    chk("t5_ex_en", 64'(op_EX_EN), 64'd1);
    tick();
    op_ready = 1'b0;
    tick(); tick(); tick();
    chk("t5_busy_ready", 64'(chng_ready), 64'd0);
    chk("t5_no_accept", 64'(rd_q.size()), 64'd3);
    chng_valid = 1'b0;
    calc_done = 1'b1;
    tick();
    calc_done = 1'b0;
    chk("t5_ready_back", 64'(chng_ready), 64'd1);

    // reset asserted during the second read
    send(1, 6, 24'h5, 24'h6);
    tick(); tick();
    chk("t6_second_rd", 64'(ymem_rd_en), 64'd1);
    chk("t6_second_addr", 64'(ymem_addr), 64'd3);
    reset = 1'b0;
    #1;
    chk("t6_rst_rd_en", 64'(ymem_rd_en), 64'd0);
    chk("t6_rst_addr", 64'(ymem_addr), 64'd0);
    chk("t6_rst_ready", 64'(chng_ready), 64'd1);
    chk("t6_rst_yrr", 64'(op_yVal_rr), 64'd0);
    chk("t6_rst_row", 64'(op_row), 64'd0);
    chk("t6_rst_delta", 64'(op_delta), 64'd0);
    tick(); tick();
    reset = 1'b1;
    tick();
    rd_q.delete();
    send(0, 2, 24'h777777, 24'h888888);
    wait_op(lat);
    chk("t6_latency", 64'(lat), 64'd5);
    chk_reads(2, 0, 4, 0);
    chk("t6_rr", 64'(op_yVal_rr), 64'(elem(0, 0)));
    chk("t6_rc", 64'(op_yVal_rc), 64'(elem(0, 2)));
    chk("t6_cc", 64'(op_yVal_cc), 64'(elem(4, 2)));
    finish_beat();

    chk("no_rd_overlap", 64'(overlap), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
